cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cpu_core.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Minimal 6502-style core: one memory read per clock, a subset of implied,
// immediate and ADC addressing modes, binary arithmetic only.
module cpu_core (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [7:0]  Data_bus,
  output logic [15:0] Addr_bus,
  output logic [7:0]  IR_dbg,
  output logic [7:0]  AC_dbg,
  output logic [7:0]  X_dbg,
  output logic [7:0]  Y_dbg,
  output logic [7:0]  P_dbg,
  output logic [15:0] PC_dbg,
  output logic [2:0]  cycle_dbg
);

  typedef enum logic [2:0] {
    CYC0 = 3'd0,
    CYC1 = 3'd1,
    CYC2 = 3'd2,
    CYC3 = 3'd3,
    CYC4 = 3'd4
  } cyc_t;

  typedef enum logic [2:0] {
    M_IMPL,
    M_IMM,
    M_ZP,
    M_ZPX,
    M_ABS,
    M_ABSX
  } mode_t;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_A,
    DST_X,
    DST_Y
  } dst_t;

  cyc_t        state, state_next;
  logic [15:0] pc, pc_next;
  logic [7:0]  ir, ir_next;
  logic [7:0]  a, a_next;
  logic [7:0]  x, x_next;
  logic [7:0]  y, y_next;
  logic [7:0]  adl, adl_next;
  logic [7:0]  adh, adh_next;
  logic        flag_n, flag_n_next;
  logic        flag_v, flag_v_next;
  logic        flag_z, flag_z_next;
  logic        flag_c, flag_c_next;

  logic [15:0] addr;
  logic        exec_alu;
  logic        exec_impl;

  mode_t       mode;
  logic [7:0]  alu_m;
  logic [8:0]  alu_sum;
  logic [7:0]  alu_res;
  logic        alu_v;
  logic [8:0]  idx_sum;

  dst_t        impl_dst;
  logic [7:0]  impl_res;
  logic        impl_c_wr;
  logic        impl_c_val;

  // IR is only meaningful from cycle 1 on; cycle 0 ignores the decode.
  always_comb begin
    mode = M_IMPL;
    case (ir)
      8'h69, 8'hE9: mode = M_IMM;
      8'h65:        mode = M_ZP;
      8'h75:        mode = M_ZPX;
      8'h6D:        mode = M_ABS;
      8'h7D:        mode = M_ABSX;
      default:      mode = M_IMPL;
    endcase
  end

  // SBC reuses the adder with the operand inverted, so carry acts as not-borrow.
  always_comb begin
    alu_m   = (ir == 8'hE9) ? ~Data_bus : Data_bus;
    alu_sum = {1'b0, a} + {1'b0, alu_m} + {8'h00, flag_c};
    alu_res = alu_sum[7:0];
    alu_v   = (a[7] ^ alu_res[7]) & (alu_m[7] ^ alu_res[7]);
    idx_sum = {1'b0, adl} + {1'b0, x};
  end

  always_comb begin
    impl_dst   = DST_NONE;
    impl_res   = 8'h00;
    impl_c_wr  = 1'b0;
    impl_c_val = 1'b0;
    case (ir)
      8'hE8: begin impl_dst = DST_X; impl_res = x + 8'd1; end
      8'hC8: begin impl_dst = DST_Y; impl_res = y + 8'd1; end
      8'hCA: begin impl_dst = DST_X; impl_res = x - 8'd1; end
      8'h88: begin impl_dst = DST_Y; impl_res = y - 8'd1; end
      8'hAA: begin impl_dst = DST_X; impl_res = a; end
      8'h8A: begin impl_dst = DST_A; impl_res = x; end
      8'hA8: begin impl_dst = DST_Y; impl_res = a; end
      8'h98: begin impl_dst = DST_A; impl_res = y; end
      8'h38: begin impl_c_wr = 1'b1; impl_c_val = 1'b1; end
      8'h18: begin impl_c_wr = 1'b1; impl_c_val = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    a_next      = a;
    x_next      = x;
    y_next      = y;
    adl_next    = adl;
    adh_next    = adh;
    flag_n_next = flag_n;
    flag_v_next = flag_v;
    flag_z_next = flag_z;
    flag_c_next = flag_c;
    addr        = pc;
    exec_alu    = 1'b0;
    exec_impl   = 1'b0;

    case (state)
      CYC0: begin
        addr       = pc;
        ir_next    = Data_bus;
        pc_next    = pc + 16'd1;
        state_next = CYC1;
      end
      CYC1: begin
        addr = pc;
        case (mode)
          M_IMPL: begin
            exec_impl  = 1'b1;
            state_next = CYC0;
          end
          M_IMM: begin
            pc_next    = pc + 16'd1;
            exec_alu   = 1'b1;
            state_next = CYC0;
          end
          default: begin
            adl_next   = Data_bus;
            pc_next    = pc + 16'd1;
            state_next = CYC2;
          end
        endcase
      end
      CYC2: begin
        case (mode)
          M_ZP: begin
            addr       = {8'h00, adl};
            exec_alu   = 1'b1;
            state_next = CYC0;
          end
          M_ZPX: begin
            addr       = {8'h00, adl};
            adl_next   = idx_sum[7:0];
            state_next = CYC3;
          end
          default: begin
            addr       = pc;
            adh_next   = Data_bus;
            pc_next    = pc + 16'd1;
            state_next = CYC3;
          end
        endcase
      end
      CYC3: begin
        state_next = CYC0;
        case (mode)
          M_ZPX: begin
            addr     = {8'h00, adl};
            exec_alu = 1'b1;
          end
          M_ABS: begin
            addr     = {adh, adl};
            exec_alu = 1'b1;
          end
          default: begin
            // A page crossing turns this read into a dummy and adds a cycle.
            addr = {adh, idx_sum[7:0]};
            if (idx_sum[8]) begin
              state_next = CYC4;
            end else begin
              exec_alu = 1'b1;
            end
          end
        endcase
      end
      CYC4: begin
        addr       = {adh + 8'd1, idx_sum[7:0]};
        exec_alu   = 1'b1;
        state_next = CYC0;
      end
      default: begin
        state_next = CYC0;
      end
    endcase

    if (exec_alu) begin
      a_next      = alu_res;
      flag_c_next = alu_sum[8];
      flag_v_next = alu_v;
      flag_z_next = (alu_res == 8'h00);
      flag_n_next = alu_res[7];
    end

    if (exec_impl) begin
      case (impl_dst)
        DST_A:   a_next = impl_res;
        DST_X:   x_next = impl_res;
        DST_Y:   y_next = impl_res;
        default: ;
      endcase
      if (impl_dst != DST_NONE) begin
        flag_n_next = impl_res[7];
        flag_z_next = (impl_res == 8'h00);
      end
      if (impl_c_wr) begin
        flag_c_next = impl_c_val;
      end
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state  <= CYC0;
      pc     <= 16'h0000;
      ir     <= 8'h00;
      a      <= 8'h00;
      x      <= 8'h00;
      y      <= 8'h00;
      adl    <= 8'h00;
      adh    <= 8'h00;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      ir     <= ir_next;
      a      <= a_next;
      x      <= x_next;
      y      <= y_next;
      adl    <= adl_next;
      adh    <= adh_next;
      flag_n <= flag_n_next;
      flag_v <= flag_v_next;
      flag_z <= flag_z_next;
      flag_c <= flag_c_next;
    end
  end

  // B, D and I are fixed at their reset values (0, 0, 1); bit 5 reads as 1.
  assign Addr_bus  = rst ? 16'h0000 : addr;
  assign IR_dbg    = ir;
  assign AC_dbg    = a;
  assign X_dbg     = x;
  assign Y_dbg     = y;
  assign P_dbg     = {flag_n, flag_v, 1'b1, 1'b0, 1'b0, 1'b1, flag_z, flag_c};
  assign PC_dbg    = pc;
  assign cycle_dbg = state;

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: instruction-level reference model driven from a
// behavioural memory, directed programs plus a randomized program.
module tb_cpu_core;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  Data_bus;
  logic [15:0] Addr_bus;
  logic [7:0]  IR_dbg, AC_dbg, X_dbg, Y_dbg, P_dbg;
  logic [15:0] PC_dbg;
  logic [2:0]  cycle_dbg;

  logic [7:0]  mem [0:65535];
  logic [7:0]  op_table [0:15] = '{8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98,
                                   8'h38, 8'h18, 8'h69, 8'hE9, 8'h65, 8'h75, 8'h6D, 8'h7D};

  int checks = 0;
  int failures = 0;

  logic [15:0] m_pc;
  logic [7:0]  m_a, m_x, m_y, m_ir;
  logic        m_n, m_v, m_z, m_c;
  logic [15:0] exp_addr [$];

  cpu_core dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .Data_bus  (Data_bus),
    .Addr_bus  (Addr_bus),
    .IR_dbg    (IR_dbg),
    .AC_dbg    (AC_dbg),
    .X_dbg     (X_dbg),
    .Y_dbg     (Y_dbg),
    .P_dbg     (P_dbg),
    .PC_dbg    (PC_dbg),
    .cycle_dbg (cycle_dbg)
  );

  assign Data_bus = mem[Addr_bus];

  always #5 clk_ph1 = ~clk_ph1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] modelP();
    return {m_n, m_v, 1'b1, 1'b0, 1'b0, 1'b1, m_z, m_c};
  endfunction

  task automatic setNZ(input logic [7:0] v);
    m_n = v[7];
    m_z = (v == 8'h00);
  endtask

  // Arithmetic on plain integers: unsigned range gives carry, signed range gives overflow.
  task automatic modelArith(input logic [7:0] m, input bit sub);
    int ua, um, ur, sa, sm, sr, cin;
    cin = m_c ? 1 : 0;
    ua  = m_a;
    um  = m;
    sa  = $signed(m_a);
    sm  = $signed(m);
    if (sub) begin
      ur  = ua - um - (1 - cin);
      sr  = sa - sm - (1 - cin);
      m_c = (ur >= 0);
    end else begin
      ur  = ua + um + cin;
      sr  = sa + sm + cin;
      m_c = (ur > 255);
    end
    m_v = (sr > 127) || (sr < -128);
    m_a = 8'(ur);
    setNZ(m_a);
  endtask

  task automatic modelReset();
    m_pc = 16'h0000;
    m_a  = 8'h00;
    m_x  = 8'h00;
    m_y  = 8'h00;
    m_ir = 8'h00;
    m_n  = 1'b0;
    m_v  = 1'b0;
    m_z  = 1'b0;
    m_c  = 1'b0;
  endtask

  // Executes one whole instruction and records every bus address it reads.
  task automatic modelInstr();
    logic [7:0]  op, lo, hi;
    logic [15:0] p1, p2, ea;
    int          sum;
    op = mem[m_pc];
    p1 = m_pc + 16'd1;
    p2 = m_pc + 16'd2;
    m_ir = op;
    exp_addr.delete();
    exp_addr.push_back(m_pc);
    case (op)
      8'h69, 8'hE9: begin
        exp_addr.push_back(p1);
        modelArith(mem[p1], op == 8'hE9);
        m_pc = p2;
      end
      8'h65: begin
        lo = mem[p1];
        exp_addr.push_back(p1);
        exp_addr.push_back({8'h00, lo});
        modelArith(mem[{8'h00, lo}], 1'b0);
        m_pc = p2;
      end
      8'h75: begin
        lo  = mem[p1];
        sum = (lo + m_x) % 256;
        ea  = 16'(sum);
        exp_addr.push_back(p1);
        exp_addr.push_back({8'h00, lo});
        exp_addr.push_back(ea);
        modelArith(mem[ea], 1'b0);
        m_pc = p2;
      end
      8'h6D: begin
        lo = mem[p1];
        hi = mem[p2];
        exp_addr.push_back(p1);
        exp_addr.push_back(p2);
        exp_addr.push_back({hi, lo});
        modelArith(mem[{hi, lo}], 1'b0);
        m_pc = m_pc + 16'd3;
      end
      8'h7D: begin
        lo  = mem[p1];
        hi  = mem[p2];
        sum = hi * 256 + lo + m_x;
        ea  = 16'(sum);
        exp_addr.push_back(p1);
        exp_addr.push_back(p2);
        if (ea[15:8] != hi) exp_addr.push_back({hi, ea[7:0]});
        exp_addr.push_back(ea);
        modelArith(mem[ea], 1'b0);
        m_pc = m_pc + 16'd3;
      end
      default: begin
        exp_addr.push_back(p1);
        m_pc = p1;
        case (op)
          8'hE8: begin m_x = m_x + 8'd1; setNZ(m_x); end
          8'hC8: begin m_y = m_y + 8'd1; setNZ(m_y); end
          8'hCA: begin m_x = m_x - 8'd1; setNZ(m_x); end
          8'h88: begin m_y = m_y - 8'd1; setNZ(m_y); end
          8'hAA: begin m_x = m_a; setNZ(m_x); end
          8'h8A: begin m_a = m_x; setNZ(m_a); end
          8'hA8: begin m_y = m_a; setNZ(m_y); end
          8'h98: begin m_a = m_y; setNZ(m_a); end
          8'h38: m_c = 1'b1;
          8'h18: m_c = 1'b0;
          default: ;
        endcase
      end
    endcase
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_a"},   AC_dbg,    m_a);
    checkOutput({tag, "_x"},   X_dbg,     m_x);
    checkOutput({tag, "_y"},   Y_dbg,     m_y);
    checkOutput({tag, "_p"},   P_dbg,     modelP());
    checkOutput({tag, "_pc"},  PC_dbg,    m_pc);
    checkOutput({tag, "_ir"},  IR_dbg,    m_ir);
    checkOutput({tag, "_cyc"}, cycle_dbg, 16'd0);
  endtask

  // Entered at a falling edge in cycle 0; leaves at the falling edge of the next cycle 0.
  task automatic applyStimulus(input string tag);
    modelInstr();
    foreach (exp_addr[i]) begin
      checkOutput({tag, "_addr"},  Addr_bus,  exp_addr[i]);
      checkOutput({tag, "_cycix"}, cycle_dbg, 16'(i));
      @(negedge clk_ph1);
    end
    checkRegs(tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk_ph1);
    @(negedge clk_ph1);
    checkOutput("rst_addr", Addr_bus,  16'h0000);
    checkOutput("rst_pc",   PC_dbg,    16'h0000);
    checkOutput("rst_a",    AC_dbg,    16'h0000);
    checkOutput("rst_x",    X_dbg,     16'h0000);
    checkOutput("rst_y",    Y_dbg,     16'h0000);
    checkOutput("rst_p",    P_dbg,     16'h0024);
    checkOutput("rst_ir",   IR_dbg,    16'h0000);
    checkOutput("rst_cyc",  cycle_dbg, 16'h0000);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic clearMem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  initial begin
    $display("[TB] starting cpu_core bench");

    clearMem();
    mem[0] = 8'hE8; mem[1] = 8'hE8; mem[2] = 8'h75; mem[3] = 8'h0A; mem[4] = 8'h7D;
    mem[5] = 8'h04; mem[6] = 8'h01; mem[7] = 8'h7D; mem[8] = 8'hFF; mem[9] = 8'h01;
    mem[16'h000C] = 8'h05; mem[16'h0106] = 8'h06; mem[16'h0201] = 8'h07;
    doReset();
    applyStimulus("seq_inx1");
    applyStimulus("seq_inx2");
    checkOutput("seq_x2", X_dbg, 16'h0002);
    applyStimulus("seq_zpx");
    checkOutput("seq_a05", AC_dbg, 16'h0005);
    applyStimulus("seq_absx4");
    checkOutput("seq_a0b", AC_dbg, 16'h000B);
    applyStimulus("seq_absx5");
    checkOutput("seq_a12", AC_dbg, 16'h0012);
    checkOutput("seq_p24", P_dbg, 16'h0024);
    applyStimulus("seq_nop");
    checkOutput("seq_nop_pc", PC_dbg, 16'h000B);

    clearMem();
    mem[0] = 8'h69; mem[1] = 8'h7F; mem[2] = 8'h69; mem[3] = 8'h01;
    doReset();
    applyStimulus("ovf_1");
    applyStimulus("ovf_2");
    checkOutput("ovf_a", AC_dbg, 16'h0080);
    checkOutput("ovf_p", P_dbg, 16'h00E4);

    clearMem();
    mem[0] = 8'h38; mem[1] = 8'hE9; mem[2] = 8'h01;
    mem[3] = 8'h38; mem[4] = 8'hE9; mem[5] = 8'hFF;
    doReset();
    applyStimulus("sbc_sec1");
    applyStimulus("sbc_1");
    checkOutput("sbc1_a", AC_dbg, 16'h00FF);
    checkOutput("sbc1_p", P_dbg, 16'h00A4);
    applyStimulus("sbc_sec2");
    applyStimulus("sbc_2");
    checkOutput("sbc2_a", AC_dbg, 16'h0000);
    checkOutput("sbc2_p", P_dbg, 16'h0027);

    clearMem();
    mem[0] = 8'hE8; mem[1] = 8'hE8; mem[2] = 8'h75; mem[3] = 8'hFF;
    mem[16'h0101] = 8'h33;
    doReset();
    applyStimulus("zpwrap_inx1");
    applyStimulus("zpwrap_inx2");
    applyStimulus("zpwrap_adc");
    checkOutput("zpwrap_a", AC_dbg, 16'h00E8);

    clearMem();
    mem[0] = 8'hCA; mem[1] = 8'h8A; mem[2] = 8'hA8; mem[3] = 8'hC8;
    doReset();
    applyStimulus("xfer_dex");
    checkOutput("xfer_x", X_dbg, 16'h00FF);
    checkOutput("xfer_p1", P_dbg, 16'h00A4);
    applyStimulus("xfer_txa");
    checkOutput("xfer_a", AC_dbg, 16'h00FF);
    applyStimulus("xfer_tay");
    checkOutput("xfer_y", Y_dbg, 16'h00FF);
    applyStimulus("xfer_iny");
    checkOutput("xfer_y0", Y_dbg, 16'h0000);
    checkOutput("xfer_p2", P_dbg, 16'h0026);

    clearMem();
    mem[0] = 8'h6D; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h1234] = 8'h55;
    doReset();
    @(negedge clk_ph1);
    @(negedge clk_ph1);
    checkOutput("midrst_cyc2", cycle_dbg, 16'd2);
    rst = 1'b1;
    @(negedge clk_ph1);
    rst = 1'b0;
    checkOutput("midrst_a",    AC_dbg,    16'h0000);
    checkOutput("midrst_pc",   PC_dbg,    16'h0000);
    checkOutput("midrst_cyc",  cycle_dbg, 16'h0000);
    checkOutput("midrst_addr", Addr_bus,  16'h0000);
    modelReset();
    applyStimulus("midrst_rerun");
    checkOutput("midrst_a55", AC_dbg, 16'h0055);

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) begin
      if ($urandom_range(0, 9) < 6) mem[i] = op_table[$urandom_range(0, 15)];
    end
    doReset();
    for (int n = 0; n < 400; n++) applyStimulus("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
